// File: rtl/anim_datapath.sv
// anim_datapath: raster clear/background fill and falling-box animation pixel datapath.
// Define ANIM_ERASE_EN to erase the previous square before each redraw (otherwise the box leaves a trail).
module anim_datapath #(
    parameter int         BOX        = 4,
    parameter int         FRAME_DIV  = 833333,
    parameter logic [2:0] BG_COLOUR  = 3'b001,
    parameter logic [2:0] OBJ_COLOUR = 3'b110,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_BG,
    input  logic       ld_coord,
    input  logic       ld_plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       draw,
    output logic       done,
    output logic       cleared
);
    localparam int FW = $clog2(FRAME_DIV + 1);
    typedef enum logic [3:0] {IDLE, CLEAR, CLR_HOLD, BG, BG_HOLD, WAIT, ERASE, DRAW, END} state_t;
`ifdef ANIM_ERASE_EN
    localparam state_t STEP_ST = ERASE, WAIT_EXIT = ERASE;
`else
    localparam state_t STEP_ST = WAIT, WAIT_EXIT = DRAW;
`endif
    state_t        r_state, w_next;
    logic [7:0]    r_sx, r_lfsr, r_obj_x, w_xmax;
    logic [6:0]    r_sy, r_obj_y;
    logic [FW-1:0] r_fcnt;
    logic          w_bg, w_co, w_pl, w_cl, w_scan, w_scan_last, w_box_last, w_frame_last, w_we, w_step;

    always_comb begin
        w_bg         = ld_BG;
        w_co         = !ld_BG && ld_coord;
        w_pl         = !ld_BG && !ld_coord && ld_plot;
        w_cl         = !ld_BG && !ld_coord && !ld_plot;
        w_scan       = r_state == CLEAR || r_state == BG;
        w_xmax       = w_scan ? 8'd159 : 8'(BOX - 1);
        w_scan_last  = r_sx == 8'd159 && r_sy == 7'd119;
        w_box_last   = r_sx == 8'(BOX - 1) && r_sy == 7'(BOX - 1);
        w_frame_last = r_fcnt == FW'(FRAME_DIV - 1);
        w_next       = IDLE;
        if (w_bg)
            w_next = (r_state == BG && w_scan_last) || r_state == BG_HOLD ? BG_HOLD : BG;
        else if (w_cl)
            w_next = r_state inside {WAIT, ERASE, DRAW, END} ? IDLE :
                     (r_state == CLEAR && w_scan_last) || r_state == CLR_HOLD ? CLR_HOLD : CLEAR;
        else if (w_pl) begin
            case (r_state)
                DRAW:    w_next = !w_box_last ? DRAW : r_obj_y == 7'(120 - BOX) ? END : WAIT;
                WAIT:    w_next = w_frame_last ? WAIT_EXIT : WAIT;
`ifdef ANIM_ERASE_EN
                ERASE:   w_next = w_box_last ? DRAW : ERASE;
`endif
                END:     w_next = END;
                default: w_next = DRAW;
            endcase
        end
        // a write only happens while the request that owns the current sequence is still the winner
        w_we   = (r_state == CLEAR && w_cl) || (r_state == BG && w_bg) ||
                 ((r_state == DRAW || r_state == ERASE) && w_pl);
        w_step = w_pl && r_state == STEP_ST && w_next == DRAW;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr  <= SEED;
            r_sx    <= '0;
            r_sy    <= '0;
            r_fcnt  <= '0;
            r_obj_x <= '0;
            r_obj_y <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
            draw    <= 1'b0;
            done    <= 1'b0;
            cleared <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            if (w_next != r_state) begin
                r_sx <= '0;
                r_sy <= '0;
            end else if (w_we) begin
                r_sx <= r_sx == w_xmax ? 8'd0 : r_sx + 8'd1;
                r_sy <= r_sx == w_xmax ? r_sy + 7'd1 : r_sy;
            end
            r_fcnt <= r_state == WAIT && w_next == WAIT ? r_fcnt + FW'(1) : '0;
            if (w_co) begin
                r_obj_x <= r_lfsr < 8'(160 - BOX) ? r_lfsr : r_lfsr - 8'd128;
                r_obj_y <= '0;
            end else if (w_step)
                r_obj_y <= r_obj_y + 7'd1;
            writeEn <= w_we;
            if (w_we) begin
                x      <= w_scan ? r_sx : r_obj_x + r_sx;
                y      <= w_scan ? r_sy : r_obj_y + r_sy;
                colour <= r_state == CLEAR ? 3'd0 : r_state == DRAW ? OBJ_COLOUR : BG_COLOUR;
            end
            draw    <= r_state == BG_HOLD && w_bg;
            done    <= r_state == END && w_pl;
            cleared <= r_state == CLR_HOLD && w_cl;
        end
    end
endmodule

// File: doc/anim_datapath.md
# anim_datapath

Pixel-generating datapath driven by the animation control FSM's load strobes (`ld_BG`, `ld_coord`, `ld_plot`). It returns the completion flags that FSM waits on (`draw`, `done`, `cleared`). It sits between the control FSM and the VGA adapter and emits one pixel write per cycle on a 160x120, 3-bit-colour frame buffer. Work performed:

- Fills the background.
- Picks a pseudo-random start column.
- Animates a falling BOX x BOX square.
- Blacks out the screen when idle.

## Interface
Parameters:
- `BOX`, 4, side of the square object in pixels (2..8).
- `FRAME_DIV`, 833333, clocks between animation steps (minimum 1).
- `BG_COLOUR`, 3'b001, background fill colour.
- `OBJ_COLOUR`, 3'b110, object colour.
- `SEED`, 8'hA5, LFSR reset value (nonzero).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ld_BG`  in  1  fill background request (level).
- `ld_coord`  in  1  latch new object start position (level, normally 1 cycle).
- `ld_plot`  in  1  run animation (level).
- `x`  out  8  pixel column, registered.
- `y`  out  7  pixel row, registered.
- `colour`  out  3  pixel colour, registered.
- `writeEn`  out  1  pixel write strobe; `x`/`y`/`colour` are valid in the same cycle.
- `draw`  out  1  background fill complete.
- `done`  out  1  object reached bottom.
- `cleared`  out  1  black clear complete.

## Operation
**Reset.** On reset low, all outputs go to 0 immediately, the LFSR loads `SEED`, `obj_x`/`obj_y` load 0 and the internal FSM enters IDLE.

**Request priority.** `ld_BG` > `ld_coord` > `ld_plot` > none (clear). A higher-priority request aborts any sequence in progress at the next edge. The scan counters restart from 0 and the flags of the aborted sequence drop.

**Internal FSM states.** IDLE, CLEAR, CLR_HOLD, BG, BG_HOLD, WAIT, ERASE, DRAW, END.

**Clear (CLEAR).**
- Entered when all load inputs are low and `cleared`=0.
- Raster-scans x 0..159 within y 0..119 with colour 0.
- After the write to (159,119), enters CLR_HOLD with `cleared`=1.
- `cleared` holds until any load input rises.

**Background (BG).**
- Entered on `ld_BG`; the same raster scan with `BG_COLOUR`.
- After pixel (159,119), enters BG_HOLD with `draw`=1.
- `draw` holds while `ld_BG`=1 and clears when `ld_BG` falls.

**Coordinate load.** On `ld_coord`:
- `obj_x` = lfsr if lfsr < 160-`BOX`, else lfsr-128.
- `obj_y` = 0.
- No pixel writes.

**LFSR.** 8-bit Fibonacci LFSR with taps 8,6,5,4. It advances every clock, including while idle.

**Animation (`ld_plot`).**
- First action: DRAW the object at (`obj_x`,`obj_y`), `BOX`² writes, row-major, `OBJ_COLOUR`.
- WAIT: the frame counter counts `FRAME_DIV` clocks.
- On terminal count:
  - ERASE the old square with `BG_COLOUR` (`BOX`² writes).
  - Increment `obj_y`.
  - DRAW at the new position.
- After a DRAW where `obj_y` == 120-`BOX`, enter END with `done`=1. `done` holds while `ld_plot`=1.
- When `ld_plot` falls in any animation state: return to IDLE, `done`=0, position retained.

**Write limits.** No writes are issued outside x 0..159 or y 0..119.

## Timing
- **Write cadence:** one pixel per cycle; `writeEn` is high exactly on write cycles.
- **Full-screen fill:** 19200 consecutive `writeEn` cycles. The flag (`draw` or `cleared`) rises on the cycle after the last write.
- **Request response:** the first write is registered on the second edge after a load input rises (edge 1 samples the request, edge 2 outputs the pixel).
- **Animation step period:** `FRAME_DIV` + 2·`BOX`² cycles (ERASE enabled).
- **Per-column ordering:** within a square, x increments fastest.
- **Counter widths:**
  - Scan counters are sized exactly for 0..159 and 0..119.
  - The frame counter is wide enough for `FRAME_DIV`.
  - There is no wrap past 159/119.

## Configuration
- `ANIM_ERASE_EN` defined:
  - ERASE runs before each DRAW after the first.
  - Only one square is visible.
- Not defined:
  - The ERASE state is compiled out and WAIT goes directly to increment+DRAW.
  - The object leaves a trail.
  - The step period is `FRAME_DIV` + `BOX`².

## Test plan
- **Reset and clear.** `reset` low mid-BG fill -> all outputs 0 immediately. Release with loads low -> 19200 writes of colour 0, then `cleared`=1.
- **Background fill.** `ld_BG` high -> writes (0,0)..(159,119) with colour 3'b001 and no gaps. `draw`=1 the cycle after (159,119). `draw`=0 one cycle after `ld_BG` falls.
- **Coordinate load.** `SEED`=8'hA5, one `ld_coord` pulse at a known cycle -> `obj_x` matches the reference LFSR model, reduced below 156, and `obj_y`=0. `SEED`=8'hFF forced case -> `obj_x`=127.
- **Animation with erase** (`BOX`=4, `FRAME_DIV`=4, `ANIM_ERASE_EN`) -> 16 writes `OBJ_COLOUR` at rows 0..3, 4 idle cycles, 16 `BG_COLOUR` erase writes, 16 writes at rows 1..4. `done`=1 after the draw at `obj_y`=116.
- **Abort.** `ld_BG` asserted during ERASE -> animation aborted, next write is (0,0) `BG_COLOUR`, `done` stays 0.
- **No erase.** Same as the erase scenario without `ANIM_ERASE_EN` -> no `BG_COLOUR` writes between DRAWs, step period 20 cycles.
